// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared helpers for the reset sequencer slice
// Purpose: counter width helper used by the sequencer and its debouncer.
package reset_sequencer_pkg;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - reset sequencer signal bundle
// Purpose: groups the button/tick inputs and the reset outputs of the sequencer.
// Ports:
//   button_n  raw front-panel reset button, active-low
//   cpu_tick  single-clk enable pulse from the clock divider
//   sys_rst   reset to the clock divider and peripherals, active-high
//   cpu_rst   reset to the CPU core, active-high
//   ready     system fully out of reset
interface reset_sequencer_if;
    logic button_n;
    logic cpu_tick;
    logic sys_rst;
    logic cpu_rst;
    logic ready;

    modport master (
        input  button_n,
        input  cpu_tick,
        output sys_rst,
        output cpu_rst,
        output ready
    );

    modport slave (
        output button_n,
        output cpu_tick,
        input  sys_rst,
        input  cpu_rst,
        input  ready
    );
endinterface

// File: rtl/reset_sequencer_button_debouncer.sv
// rtl/reset_sequencer_button_debouncer.sv - 2-flop synchroniser plus debounce counter
// Purpose: turns a raw active-low button into a clean pressed level.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   btn_n_raw  raw asynchronous button, active-low
//   pressed    debounced pressed level
module button_debouncer
    import reset_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_raw,
    output logic pressed
);
    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Exposing the next level lets the sequencer act on the same edge the
    // debounced level flips, keeping press-to-reset at sync + debounce clocks.
    assign pressed = ~level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered system/CPU reset generator
// Purpose: holds sys_rst for POR_CYCLES clocks, then cpu_rst for CPU_RST_TICKS
//          divider ticks, and restarts the sequence on a debounced button press.
// Ports:
//   clk  system clock
//   rst  synchronous active-high global reset
//   bus  reset_sequencer_if master: button_n, cpu_tick in; sys_rst, cpu_rst, ready out
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int POR_CYCLES      = 1024,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CPU_RST_TICKS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    reset_sequencer_if.master     bus
);
    localparam logic [1:0] ST_POR      = 2'd0;
    localparam logic [1:0] ST_CPU_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_BUTTON   = 2'd3;

    localparam int POR_W  = cnt_width(POR_CYCLES);
    localparam int TICK_W = cnt_width(CPU_RST_TICKS);
    localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CPU_RST_TICKS - 1);

    logic              btn_pressed;
    logic [1:0]        state_q, state_d;
    logic [POR_W-1:0]  por_cnt_q, por_cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              sys_rst_q, cpu_rst_q, ready_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .rst      (rst),
        .btn_n_raw(bus.button_n),
        .pressed  (btn_pressed)
    );

    always_comb begin
        state_d    = state_q;
        por_cnt_d  = por_cnt_q;
        tick_cnt_d = tick_cnt_q;
        case (state_q)
            ST_POR: begin
                if (btn_pressed) begin
                    por_cnt_d = '0;
                end else if (por_cnt_q == POR_LAST) begin
                    state_d    = ST_CPU_HOLD;
                    por_cnt_d  = '0;
                    tick_cnt_d = '0;
                end else begin
                    por_cnt_d = por_cnt_q + 1'b1;
                end
            end
            ST_CPU_HOLD: begin
                // A press wins over a coincident final tick.
                if (btn_pressed) begin
                    state_d = ST_BUTTON;
                end else if (bus.cpu_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (btn_pressed) begin
                    state_d = ST_BUTTON;
                end
            end
            ST_BUTTON: begin
                if (!btn_pressed) begin
                    state_d   = ST_POR;
                    por_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_POR;
                por_cnt_d  = '0;
                tick_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_POR;
            por_cnt_q  <= '0;
            tick_cnt_q <= '0;
            sys_rst_q  <= 1'b1;
            cpu_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            por_cnt_q  <= por_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            sys_rst_q  <= (state_d == ST_POR) || (state_d == ST_BUTTON);
            cpu_rst_q  <= (state_d != ST_RUN);
            ready_q    <= (state_d == ST_RUN);
        end
    end

    assign bus.sys_rst = sys_rst_q;
    assign bus.cpu_rst = cpu_rst_q;
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;
    logic clk;
    logic rst;
    reset_sequencer_if bus();

    reset_sequencer #(
        .POR_CYCLES     (16),
        .DEBOUNCE_CYCLES(8),
        .CPU_RST_TICKS  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic tick_auto    = 1'b1;
    int   tick_phase   = 0;
    logic applied_tick = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge; outputs are sampled 1 ns after it.
    task automatic step();
        if (tick_auto) begin
            bus.cpu_tick = (tick_phase == 4);
            tick_phase   = (tick_phase == 4) ? 0 : tick_phase + 1;
        end
        applied_tick = bus.cpu_tick;
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until sys_rst equals val, or -1.
    task automatic wait_sys(input logic val, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (bus.sys_rst == val) begin
                n = i;
                break;
            end
        end
    endtask

    // From the moment sys_rst is seen low, cpu_rst must fall on the 4th tick.
    task automatic cpu_release(input string tag);
        int ticks;
        int n;
        ticks = 0;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (applied_tick) ticks++;
            if (!bus.cpu_rst) begin
                n = i;
                break;
            end
        end
        check_eq({tag, "_cpu_rst_fell"}, (n > 0) ? 1 : 0, 1);
        check_eq({tag, "_ticks"}, ticks, 4);
        check_eq({tag, "_on_tick"}, int'(applied_tick), 1);
        check_eq({tag, "_ready"}, int'(bus.ready), 1);
        check_eq({tag, "_sys_rst"}, int'(bus.sys_rst), 0);
    endtask

    initial begin
        int   n;
        logic all_ok;
        logic seen;

        rst          = 1'b1;
        bus.button_n = 1'b1;
        bus.cpu_tick = 1'b0;

        // 1: power-on sequence
        repeat (3) step();
        check_eq("t1_rst_sys_rst", int'(bus.sys_rst), 1);
        check_eq("t1_rst_cpu_rst", int'(bus.cpu_rst), 1);
        check_eq("t1_rst_ready", int'(bus.ready), 0);
        rst = 1'b0;
        wait_sys(1'b0, n);
        check_eq("t1_sys_rst_edges", n, 16);
        check_eq("t1_cpu_rst_held", int'(bus.cpu_rst), 1);
        check_eq("t1_ready_low", int'(bus.ready), 0);
        cpu_release("t1");

        // 2: short glitch in RUN is rejected
        bus.button_n = 1'b0;
        all_ok = 1'b1;
        repeat (5) begin
            step();
            if (!bus.ready || bus.sys_rst) all_ok = 1'b0;
        end
        bus.button_n = 1'b1;
        repeat (20) begin
            step();
            if (!bus.ready || bus.sys_rst) all_ok = 1'b0;
        end
        check_eq("t2_glitch_rejected", int'(all_ok), 1);

        // 3: long press in RUN
        bus.button_n = 1'b0;
        wait_sys(1'b1, n);
        check_eq("t3_press_edges", n, 10);
        check_eq("t3_press_cpu_rst", int'(bus.cpu_rst), 1);
        check_eq("t3_press_ready", int'(bus.ready), 0);
        repeat (30) step();
        bus.button_n = 1'b1;
        wait_sys(1'b0, n);
        check_eq("t3_release_edges", n, 26);
        cpu_release("t3");

        // 4: button held through rst release
        rst          = 1'b1;
        bus.button_n = 1'b0;
        repeat (3) step();
        rst  = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            step();
            if (!bus.sys_rst) seen = 1'b1;
        end
        check_eq("t4_sys_rst_held", int'(seen), 0);
        bus.button_n = 1'b1;
        wait_sys(1'b0, n);
        check_eq("t4_release_edges", n, 25);
        cpu_release("t4");

        // 5: debounced press coincides with the final tick
        rst          = 1'b1;
        tick_auto    = 1'b0;
        bus.cpu_tick = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        wait_sys(1'b0, n);
        check_eq("t5_sys_rst_edges", n, 16);
        repeat (3) begin
            bus.cpu_tick = 1'b1;
            step();
            bus.cpu_tick = 1'b0;
            step();
        end
        bus.button_n = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            step();
            if (!bus.cpu_rst || bus.ready) seen = 1'b1;
        end
        bus.cpu_tick = 1'b1;
        step();
        bus.cpu_tick = 1'b0;
        check_eq("t5_sys_rst_button", int'(bus.sys_rst), 1);
        check_eq("t5_cpu_rst_kept", int'(bus.cpu_rst), 1);
        check_eq("t5_ready_low", int'(bus.ready), 0);
        repeat (20) begin
            step();
            if (!bus.cpu_rst || bus.ready) seen = 1'b1;
        end
        check_eq("t5_never_released", int'(seen), 0);
        bus.button_n = 1'b1;
        tick_auto    = 1'b1;
        wait_sys(1'b0, n);
        check_eq("t5_release_edges", n, 26);
        cpu_release("t5");

        // 6: one-clock rst pulse in RUN
        rst = 1'b1;
        step();
        check_eq("t6_sys_rst", int'(bus.sys_rst), 1);
        check_eq("t6_cpu_rst", int'(bus.cpu_rst), 1);
        check_eq("t6_ready", int'(bus.ready), 0);
        rst = 1'b0;
        wait_sys(1'b0, n);
        check_eq("t6_sys_rst_edges", n, 16);
        cpu_release("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
